// File: rtl/iob_rd_addr_gen.sv
// rtl/iob_rd_addr_gen.sv - IO_Buffer read-address sequencer: walks a padded tile row-major, one beat per cycle.
// Pad positions issue pad_en beats; interior positions issue rd_en beats at row_base + column offset.
module iob_rd_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8,
  parameter int PAD_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_row_stride,
  input  logic [DIM_W-1:0]  i_rows,
  input  logic [DIM_W-1:0]  i_cols,
  input  logic [PAD_W-1:0]  i_pad_top,
  input  logic [PAD_W-1:0]  i_pad_bot,
  input  logic [PAD_W-1:0]  i_pad_left,
  input  logic [PAD_W-1:0]  i_pad_right,
  input  logic              i_stall,
  output logic [ADDR_W-1:0] o_iob_raddr,
  output logic              o_iob_rd_en,
  output logic              o_iob_pad_en,
  output logic              o_busy,
  output logic              o_done
);

  // One extra bit so that padded frame dimensions never overflow the counters.
  localparam int CW = DIM_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     row, col;
  logic [CW-1:0]     row_lo, row_hi, col_lo, col_hi;
  logic [CW-1:0]     last_row, last_col;
  logic [DIM_W-1:0]  icol;
  logic [ADDR_W-1:0] row_base, row_stride;

  logic in_row, in_col, at_row_end, at_frame_end;

  always_comb begin
    in_row       = (row >= row_lo) && (row < row_hi);
    in_col       = (col >= col_lo) && (col < col_hi);
    at_row_end   = (col == last_col);
    at_frame_end = at_row_end && (row == last_row);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      icol         <= '0;
      row_lo       <= '0;
      row_hi       <= '0;
      col_lo       <= '0;
      col_hi       <= '0;
      last_row     <= '0;
      last_col     <= '0;
      row_base     <= '0;
      row_stride   <= '0;
      o_iob_raddr  <= '0;
      o_iob_rd_en  <= 1'b0;
      o_iob_pad_en <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_iob_rd_en  <= 1'b0;
      o_iob_pad_en <= 1'b0;
      o_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (i_start && !o_done) begin
            row        <= '0;
            col        <= '0;
            icol       <= '0;
            row_base   <= i_base_addr;
            row_stride <= i_row_stride;
            row_lo     <= CW'(i_pad_top);
            row_hi     <= CW'(i_pad_top) + CW'(i_rows);
            col_lo     <= CW'(i_pad_left);
            col_hi     <= CW'(i_pad_left) + CW'(i_cols);
            last_row   <= CW'(i_pad_top) + CW'(i_rows) + CW'(i_pad_bot) - CW'(1);
            last_col   <= CW'(i_pad_left) + CW'(i_cols) + CW'(i_pad_right) - CW'(1);
            o_busy     <= 1'b1;
            state      <= (i_rows == '0 || i_cols == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (!i_stall) begin
            if (in_row && in_col) begin
              o_iob_rd_en <= 1'b1;
              o_iob_raddr <= row_base + ADDR_W'(icol);
              icol        <= icol + DIM_W'(1);
            end else begin
              o_iob_pad_en <= 1'b1;
              o_iob_raddr  <= '0;
            end
            if (at_row_end) begin
              col  <= '0;
              icol <= '0;
              row  <= row + CW'(1);
              if (in_row) row_base <= row_base + row_stride;
            end else begin
              col <= col + CW'(1);
            end
            if (at_frame_end) state <= S_DONE;
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_rd_addr_gen.sv
// tb/tb_iob_rd_addr_gen.sv - randomized self-checking bench for iob_rd_addr_gen against a frame-level beat model.
module tb_iob_rd_addr_gen;
  localparam int ADDR_W = 12;
  localparam int DIM_W  = 8;
  localparam int PAD_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr, i_row_stride;
  logic [DIM_W-1:0]  i_rows, i_cols;
  logic [PAD_W-1:0]  i_pad_top, i_pad_bot, i_pad_left, i_pad_right;
  logic              i_stall;
  logic [ADDR_W-1:0] o_iob_raddr;
  logic              o_iob_rd_en, o_iob_pad_en, o_busy, o_done;

  int n_checks = 0;
  int n_errors = 0;
  int exp_raddr = 0;

  iob_rd_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .PAD_W(PAD_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_row_stride(i_row_stride),
    .i_rows(i_rows), .i_cols(i_cols),
    .i_pad_top(i_pad_top), .i_pad_bot(i_pad_bot),
    .i_pad_left(i_pad_left), .i_pad_right(i_pad_right),
    .i_stall(i_stall),
    .o_iob_raddr(o_iob_raddr), .o_iob_rd_en(o_iob_rd_en), .o_iob_pad_en(o_iob_pad_en),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_cfg();
    i_base_addr  = ADDR_W'($urandom);
    i_row_stride = ADDR_W'($urandom);
    i_rows       = DIM_W'($urandom);
    i_cols       = DIM_W'($urandom);
    i_pad_top    = PAD_W'($urandom);
    i_pad_bot    = PAD_W'($urandom);
    i_pad_left   = PAD_W'($urandom);
    i_pad_right  = PAD_W'($urandom);
  endtask

  task automatic check_quiet(input string tag, input logic busy_exp);
    check({tag, "_rd_en"},  o_iob_rd_en,  0);
    check({tag, "_pad_en"}, o_iob_pad_en, 0);
    check({tag, "_busy"},   o_busy,       busy_exp);
    check({tag, "_done"},   o_done,       0);
  endtask

  // Runs one frame: the expected beat list is built from the frame geometry,
  // then outputs are compared cycle by cycle while stalls are injected.
  task automatic run_job(input int rows, input int cols, input int pt, input int pb,
                         input int pl, input int pr, input int base, input int stride,
                         input int stall_pct, input int stall_at, input int stall_len,
                         input bit poke);
    int  e_rd[$], e_pad[$], e_addr[$];
    int  n, idx, cyc, sc, rsel;
    bit  st, interior;
    if (rows > 0 && cols > 0) begin
      for (int r = 0; r < pt + rows + pb; r++) begin
        for (int c = 0; c < pl + cols + pr; c++) begin
          interior = (r >= pt) && (r < pt + rows) && (c >= pl) && (c < pl + cols);
          e_rd.push_back(interior ? 1 : 0);
          e_pad.push_back(interior ? 0 : 1);
          e_addr.push_back(interior ? ((base + (r - pt) * stride + (c - pl)) % 4096) : 0);
        end
      end
    end
    n = e_rd.size();

    @(negedge clk);
    i_start      = 1'b1;
    i_base_addr  = ADDR_W'(base);
    i_row_stride = ADDR_W'(stride);
    i_rows       = DIM_W'(rows);
    i_cols       = DIM_W'(cols);
    i_pad_top    = PAD_W'(pt);
    i_pad_bot    = PAD_W'(pb);
    i_pad_left   = PAD_W'(pl);
    i_pad_right  = PAD_W'(pr);
    i_stall      = 1'($urandom);
    @(negedge clk);
    i_start = 1'b0;
    scramble_cfg();
    check_quiet("accept", 1'b1);

    idx = 0; cyc = 0; sc = 0;
    while (idx < n && cyc < 4 * n + 50) begin
      if (idx == stall_at && sc < stall_len) begin
        st = 1'b1;
        sc++;
      end else begin
        st = ($urandom_range(99) < stall_pct);
      end
      i_stall = st;
      i_start = poke && ($urandom_range(3) == 0);
      if (i_start) scramble_cfg();
      @(negedge clk);
      if (st) begin
        check("stall_rd_en",  o_iob_rd_en,  0);
        check("stall_pad_en", o_iob_pad_en, 0);
        check("stall_raddr",  o_iob_raddr,  exp_raddr);
      end else begin
        check("beat_rd_en",  o_iob_rd_en,  e_rd[idx]);
        check("beat_pad_en", o_iob_pad_en, e_pad[idx]);
        check("beat_raddr",  o_iob_raddr,  e_addr[idx]);
        exp_raddr = e_addr[idx];
        idx++;
      end
      check("run_busy", o_busy, 1);
      check("run_done", o_done, 0);
      cyc++;
    end
    if (idx != n) check("beat_timeout", idx, n);

    i_start = 1'b0;
    i_stall = 1'($urandom);
    @(negedge clk);
    check("done_pulse",  o_done,       1);
    check("done_busy",   o_busy,       0);
    check("done_rd_en",  o_iob_rd_en,  0);
    check("done_pad_en", o_iob_pad_en, 0);

    rsel = $urandom_range(1);
    i_start = 1'b1;
    if (rsel == 1) scramble_cfg();
    @(negedge clk);
    i_start = 1'b0;
    check_quiet("start_at_done_ignored", 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_stall = 1'b0;
    scramble_cfg();
    repeat (3) @(negedge clk);
    check("rst_raddr", o_iob_raddr, 0);
    check_quiet("rst", 1'b0);
    rst = 1'b0;
    exp_raddr = 0;
    @(negedge clk);

    run_job(2, 3, 0, 0, 0, 0, 'h010, 4, 0, -1, 0, 0);
    run_job(1, 1, 1, 1, 1, 1, 'h020, 7, 0, -1, 0, 0);
    run_job(2, 2, 0, 0, 0, 0, 'h000, 2, 0, 2, 3, 0);
    run_job(2, 3, 0, 0, 0, 0, 'hFFE, 3, 0, -1, 0, 0);
    run_job(0, 5, 2, 2, 2, 2, 'h123, 9, 0, -1, 0, 0);
    run_job(4, 0, 1, 1, 1, 1, 'h123, 9, 0, -1, 0, 0);

    // Abort mid-frame with reset: everything clears, no done pulse follows.
    @(negedge clk);
    i_start = 1'b1;
    i_base_addr = 12'h300; i_row_stride = 12'h010;
    i_rows = 8'd3; i_cols = 8'd4;
    i_pad_top = 3'd1; i_pad_bot = 3'd1; i_pad_left = 3'd1; i_pad_right = 3'd1;
    i_stall = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", o_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_raddr = 0;
    check("mid_rst_raddr", o_iob_raddr, 0);
    check_quiet("mid_rst", 1'b0);
    repeat (4) begin
      @(negedge clk);
      check_quiet("post_rst", 1'b0);
    end

    run_job(2, 3, 0, 0, 0, 0, 'h010, 4, 0, -1, 0, 1);
    run_job(3, 4, 1, 2, 2, 1, 'h7F0, 'h105, 30, -1, 0, 1);

    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(5), $urandom_range(5), $urandom_range(7), $urandom_range(7),
              $urandom_range(7), $urandom_range(7), $urandom_range(4095), $urandom_range(4095),
              $urandom_range(40), -1, 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  always @(negedge clk) begin
    if (!rst && o_iob_rd_en && o_iob_pad_en) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobe_exclusive: got rd_en=1 pad_en=1 expected at most one high at %0t", $time);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish within 2ms");
    $fatal(1, "timeout");
  end
endmodule
